// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - programmable 4-LED pattern sequencer with prescaled dwell and start/pause/stop
module led_seq_ctrl #(
    parameter int PRESC_DIV = 50000,
    parameter int PRESC_W   = 16,
    parameter int DWELL_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_mode,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               start,
    input  logic               pause,
    input  logic               stop,
    output logic [3:0]         led,
    output logic               busy,
    output logic               step_pulse
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

    state_t             state;
    logic [1:0]         mode_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [PRESC_W-1:0] presc_cnt;
    logic               dir_up;

    logic               cfg_accept;
    logic [1:0]         start_mode;
    logic [3:0]         init_led;
    logic [3:0]         step_led;
    logic               step_dir_up;
    logic               tick;
    logic               bad_state;

    assign cfg_accept = cfg_valid && cfg_ready;
    assign tick       = (presc_cnt == PRESC_LAST);
    assign bad_state  = (state != S_IDLE) && (state != S_RUN) && (state != S_PAUSE);

    // A start that coincides with a config accept launches with the new mode.
    assign start_mode = cfg_accept ? cfg_mode : mode_r;

    always_comb begin
        init_led = 4'b0001;
        case (start_mode)
            2'd1:    init_led = 4'b1000;
            2'd3:    init_led = 4'b1111;
            default: init_led = 4'b0001;
        endcase
    end

    always_comb begin
        step_led    = led;
        step_dir_up = dir_up;
        case (mode_r)
            2'd0: step_led = {led[2:0], led[3]};
            2'd1: step_led = {led[0], led[3:1]};
            2'd2: begin
                // End LEDs turn the direction around so they are lit for one step only.
                if (dir_up) begin
                    if (led[3]) begin
                        step_led    = {1'b0, led[3:1]};
                        step_dir_up = 1'b0;
                    end else begin
                        step_led = {led[2:0], 1'b0};
                    end
                end else begin
                    if (led[0]) begin
                        step_led    = {led[2:0], 1'b0};
                        step_dir_up = 1'b1;
                    end else begin
                        step_led = {1'b0, led[3:1]};
                    end
                end
            end
            default: step_led = ~led;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            led        <= 4'b0000;
            busy       <= 1'b0;
            step_pulse <= 1'b0;
            cfg_ready  <= 1'b1;
            mode_r     <= 2'd0;
            dwell_r    <= '0;
            presc_cnt  <= '0;
            dwell_cnt  <= '0;
            dir_up     <= 1'b1;
        end else begin
            step_pulse <= 1'b0;
            if (stop || bad_state) begin
                state     <= S_IDLE;
                led       <= 4'b0000;
                busy      <= 1'b0;
                cfg_ready <= 1'b1;
                presc_cnt <= '0;
                dwell_cnt <= '0;
                dir_up    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        led       <= 4'b0000;
                        presc_cnt <= '0;
                        dwell_cnt <= '0;
                        if (cfg_accept) begin
                            mode_r  <= cfg_mode;
                            dwell_r <= cfg_dwell;
                        end
                        if (start) begin
                            state     <= S_RUN;
                            led       <= init_led;
                            dir_up    <= 1'b1;
                            busy      <= 1'b1;
                            cfg_ready <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        // The pausing edge itself does not advance the counters.
                        if (pause) begin
                            state <= S_PAUSE;
                        end else if (tick) begin
                            presc_cnt <= '0;
                            if (dwell_cnt == dwell_r) begin
                                dwell_cnt  <= '0;
                                led        <= step_led;
                                dir_up     <= step_dir_up;
                                step_pulse <= 1'b1;
                            end else begin
                                dwell_cnt <= dwell_cnt + DWELL_W'(1);
                            end
                        end else begin
                            presc_cnt <= presc_cnt + PRESC_W'(1);
                        end
                    end
                    S_PAUSE: begin
                        if (pause) begin
                            state <= S_RUN;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
